// File: rtl/arb_pkg.sv
// arb_pkg: shared arbiter constants and data word type
package arb_pkg;
   localparam int ARB_DATA_W = 32;
   localparam int ARB_NUM_CH = 8;
   typedef logic [ARB_DATA_W-1:0] arb_data_t;
endpackage

// File: rtl/arb_fifo_mem.sv
// arb_fifo_mem: DEPTH x DATA_W storage with synchronous write and asynchronous read
module arb_fifo_mem
   import arb_pkg::*;
#(
   parameter int DATA_W = ARB_DATA_W,
   parameter int DEPTH  = 8
) (
   input  logic                     clk,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [DATA_W-1:0]        wdata_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [DATA_W-1:0]        rdata_o
);
   logic [DATA_W-1:0] mem_q [DEPTH];
   // write port; contents are never cleared
   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end
   assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/arb_out_fifo.sv
// arb_out_fifo: elastic FIFO after the arbiter; ARB_OUT_FIFO_STATS_EN adds push/stall counters
module arb_out_fifo
   import arb_pkg::*;
#(
   parameter int DATA_W   = ARB_DATA_W,
   parameter int DEPTH    = 8,
   parameter int AFULL_TH = 6
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       valid_i,
   input  logic [DATA_W-1:0]          data_i,
   output logic                       ready_i,
   output logic                       valid_o,
   output logic [DATA_W-1:0]          data_o,
   input  logic                       ready_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
`ifdef ARB_OUT_FIFO_STATS_EN
   output logic [31:0]                stat_push_o,
   output logic [31:0]                stat_stall_o,
`endif
   output logic                       almost_full
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic push, pop;
   logic [DATA_W-1:0] rdata;
   // flags come only from registered count, so no input-to-output combinational path
   assign ready_i     = count_q != CW'(DEPTH);
   assign valid_o     = count_q != '0;
   assign count_o     = count_q;
   assign almost_full = count_q >= CW'(AFULL_TH);
   assign data_o      = valid_o ? rdata : '0;
   assign push        = valid_i & ready_i;
   assign pop         = valid_o & ready_o;
   // pointer and occupancy next state; pointers wrap naturally at DEPTH
   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q + CW'(push) - CW'(pop);
   end
   // state registers; reset discards all stored words
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end
   arb_fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
      .clk     (clk),
      .we_i    (push & ~reset),
      .waddr_i (wr_ptr_q),
      .wdata_i (data_i),
      .raddr_i (rd_ptr_q),
      .rdata_o (rdata)
   );
`ifdef ARB_OUT_FIFO_STATS_EN
   logic [31:0] push_cnt_q, stall_cnt_q;
   assign stat_push_o  = push_cnt_q;
   assign stat_stall_o = stall_cnt_q;
   // saturating push and stall counters
   always_ff @(posedge clk) begin
      if (reset) begin
         push_cnt_q  <= '0;
         stall_cnt_q <= '0;
      end else begin
         push_cnt_q  <= push_cnt_q + 32'(push && push_cnt_q != '1);
         stall_cnt_q <= stall_cnt_q + 32'(valid_i && !ready_i && stall_cnt_q != '1);
      end
   end
`endif
endmodule

// File: tb/tb_arb_out_fifo.sv
// tb_arb_out_fifo: scoreboard bench for arb_out_fifo
module tb_arb_out_fifo;
   logic        clk = 0, reset = 1, valid_i = 0, ready_o = 0;
   logic [31:0] data_i = '0;
   logic        ready_i, valid_o, almost_full;
   logic [31:0] data_o;
   logic [3:0]  count_o;
   int n_cmp = 0, n_err = 0;
   logic [31:0] sb_q [$];
`ifdef ARB_OUT_FIFO_STATS_EN
   logic [31:0] stat_push_o, stat_stall_o;
   int m_push = 0, m_stall = 0;
`endif
   always #5 clk = ~clk;
   arb_out_fifo dut (
      .clk(clk), .reset(reset), .valid_i(valid_i), .data_i(data_i), .ready_i(ready_i),
      .valid_o(valid_o), .data_o(data_o), .ready_o(ready_o), .count_o(count_o),
`ifdef ARB_OUT_FIFO_STATS_EN
      .stat_push_o(stat_push_o), .stat_stall_o(stat_stall_o),
`endif
      .almost_full(almost_full)
   );
   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask
   task automatic step();
      int  n = sb_q.size();
      bit  do_pop = n > 0 && ready_o;
      bit  do_push = valid_i && n < 8;
      chk("ready_i", ready_i, n != 8);
      chk("valid_o", valid_o, n != 0);
      chk("count_o", count_o, n);
      chk("almost_full", almost_full, n >= 6);
`ifdef ARB_OUT_FIFO_STATS_EN
      chk("stat_push", stat_push_o, m_push);
      chk("stat_stall", stat_stall_o, m_stall);
`endif
      if (do_pop) chk("data_o", data_o, sb_q[0]);
      if (reset) begin
         sb_q.delete();
`ifdef ARB_OUT_FIFO_STATS_EN
         m_push = 0; m_stall = 0;
`endif
      end else begin
         if (do_pop) void'(sb_q.pop_front());
         if (do_push) sb_q.push_back(data_i);
`ifdef ARB_OUT_FIFO_STATS_EN
         m_push += int'(do_push);
         m_stall += int'(valid_i && n == 8);
`endif
      end
      @(posedge clk);
      @(negedge clk);
   endtask
   task automatic drain();
      valid_i = 0;
      ready_o = 1;
      for (int i = 0; i < 20 && sb_q.size() > 0; i++) step();
      chk("drained", sb_q.size(), 0);
   endtask
   initial begin
      @(negedge clk);
      step();
      step();
      reset = 0;
      for (int i = 0; i < 10; i++) step();
      ready_o = 0;
      valid_i = 1;
      for (int i = 0; i < 8; i++) begin
         data_i = 32'hA0 + 32'(i);
         step();
      end
      chk("full_count", count_o, 8);
      chk("full_ready", ready_i, 0);
      data_i = 32'hA8;
      step();
      ready_o = 1;
      data_i = 32'hB0;
      chk("pop_head", data_o, 32'hA0);
      step();
      chk("after_first_pop", count_o, 7);
      data_i = 32'hB1;
      step();
      chk("push_pop_count", count_o, 7);
      drain();
      valid_i = 1;
      ready_o = 1;
      for (int i = 0; i < 20; i++) begin
         data_i = 32'hC0 + 32'(i);
         step();
         chk("stream_count", count_o, 1);
      end
      drain();
      for (int r = 0; r < 8; r++) begin
         valid_i = 1;
         ready_o = 0;
         for (int i = 0; i < 3; i++) begin
            data_i = 32'h100 + 32'(r * 3 + i);
            step();
         end
         valid_i = 0;
         ready_o = 1;
         for (int i = 0; i < 3; i++) step();
      end
      chk("wrap_count", count_o, 0);
      valid_i = 1;
      ready_o = 0;
      for (int i = 0; i < 5; i++) begin
         data_i = 32'hD0 + 32'(i);
         step();
      end
      chk("pre_reset_count", count_o, 5);
      reset = 1;
      ready_o = 1;
      data_i = 32'hEE;
      step();
      reset = 0;
      valid_i = 0;
      chk("rst_count", count_o, 0);
      chk("rst_valid", valid_o, 0);
      chk("rst_ready", ready_i, 1);
      valid_i = 1;
      ready_o = 0;
      data_i = 32'h55;
      step();
      valid_i = 0;
      chk("post_rst_first", data_o, 32'h55);
      drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
